// File: rtl/noc_params.sv
// Shared NoC link parameters and types for the credit-based transmitter.
// Optional checking in the transmitter is enabled with the CREDIT_CHECK_EN macro.
package noc_params;

  localparam int VC_NUM   = 2;
  localparam int VC_DEPTH = 4;
  localparam int DATA_W   = 16;

  typedef enum logic [1:0] {HEAD, BODY, TAIL, HEADTAIL} flit_label_t;

  typedef enum logic {IDLE, ACTIVE} vc_state_t;

  typedef struct packed {
    flit_label_t       flit_label;
    logic [DATA_W-1:0] data;
  } flit_t;

  // True for labels that open a packet and therefore expect an idle VC.
  function automatic logic is_head(input flit_label_t label);
    return (label == HEAD) || (label == HEADTAIL);
  endfunction

endpackage

// File: rtl/credit_counter.sv
// Free-slot counter for one downstream VC buffer. Starts full, counts down on
// each flit sent and up on each credit returned, saturating at BUFFER_SIZE.
module credit_counter #(
  parameter int  BUFFER_SIZE = 4,
  localparam int CW          = $clog2(BUFFER_SIZE + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          dec_i,
  input  logic          inc_i,
  output logic [CW-1:0] credit_o,
  output logic          nonzero_o,
  output logic          full_o,
  output logic          overflow_o
);

  // Simultaneous send and return cancel; a return while already full is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      credit_o <= CW'(BUFFER_SIZE);
    end else if (dec_i && !inc_i) begin
      credit_o <= credit_o - CW'(1);
    end else if (inc_i && !dec_i && !full_o) begin
      credit_o <= credit_o + CW'(1);
    end
  end

  assign nonzero_o  = (credit_o != '0);
  assign full_o     = (credit_o == CW'(BUFFER_SIZE));
  assign overflow_o = inc_i && full_o;

endmodule

// File: rtl/vc_credit_tx.sv
// Credit-based output-port transmitter for one router output link.
// Forwards flits only when the target downstream VC has credit, tracks per-VC
// packet ownership, and reports which downstream VCs are completely free.
// Define CREDIT_CHECK_EN to enable the sticky protocol-error flag on error_o.
module vc_credit_tx
  import noc_params::*;
#(
  parameter int  VC_NUM      = noc_params::VC_NUM,
  parameter int  BUFFER_SIZE = noc_params::VC_DEPTH,
  localparam int VC_ID_W     = (VC_NUM > 1) ? $clog2(VC_NUM) : 1,
  localparam int CW          = $clog2(BUFFER_SIZE + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  flit_t              flit_i,
  input  logic               valid_i,
  input  logic [VC_ID_W-1:0] vc_id_i,
  output logic               ready_o,
  output flit_t              flit_o,
  output logic               valid_o,
  output logic [VC_ID_W-1:0] vc_id_o,
  input  logic [VC_NUM-1:0]  credit_i,
  output logic [VC_NUM-1:0]  vc_free_o,
  output logic               error_o
);

  logic [VC_NUM-1:0]         send_vc;
  logic [VC_NUM-1:0]         nonzero;
  logic [VC_NUM-1:0]         full;
  logic [VC_NUM-1:0]         credit_overflow;
  logic [VC_NUM-1:0][CW-1:0] credit;
  vc_state_t                 vc_state [VC_NUM];
  logic                      vc_in_range;
  logic                      transfer;

  assign vc_in_range = (32'(vc_id_i) < 32'(VC_NUM));
  assign ready_o     = vc_in_range && nonzero[vc_id_i];
  assign transfer    = valid_i && ready_o;

  for (genvar v = 0; v < VC_NUM; v++) begin : g_vc
    assign send_vc[v]   = transfer && (vc_id_i == VC_ID_W'(v));
    assign vc_free_o[v] = (vc_state[v] == IDLE) && full[v];

    credit_counter #(
      .BUFFER_SIZE(BUFFER_SIZE)
    ) u_credit (
      .clk       (clk),
      .rst       (rst),
      .dec_i     (send_vc[v]),
      .inc_i     (credit_i[v]),
      .credit_o  (credit[v]),
      .nonzero_o (nonzero[v]),
      .full_o    (full[v]),
      .overflow_o(credit_overflow[v])
    );
  end

  // Per-VC ownership: a HEAD claims the VC, a TAIL or HEADTAIL releases it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int v = 0; v < VC_NUM; v++) vc_state[v] <= IDLE;
    end else begin
      for (int v = 0; v < VC_NUM; v++) begin
        if (send_vc[v]) begin
          case (flit_i.flit_label)
            HEAD:           vc_state[v] <= ACTIVE;
            TAIL, HEADTAIL: vc_state[v] <= IDLE;
            default:        vc_state[v] <= vc_state[v];
          endcase
        end
      end
    end
  end

  // Link output register: capture accepted flits, hold data between transfers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_o <= 1'b0;
      flit_o  <= '0;
      vc_id_o <= '0;
    end else begin
      valid_o <= transfer;
      if (transfer) begin
        flit_o  <= flit_i;
        vc_id_o <= vc_id_i;
      end
    end
  end

  // The raw credit levels are only needed for debug visibility.
  logic unused_credit;
  assign unused_credit = ^credit;

`ifdef CREDIT_CHECK_EN
  logic ownership_violation;
  logic error_event;
  logic error_q;

  // Detect a packet opening on an owned VC or continuing on an unowned one.
  always_comb begin
    ownership_violation = 1'b0;
    for (int v = 0; v < VC_NUM; v++) begin
      if (send_vc[v]) begin
        if (is_head(flit_i.flit_label) == (vc_state[v] == ACTIVE)) begin
          ownership_violation = 1'b1;
        end
      end
    end
  end

  assign error_event = ownership_violation || (|credit_overflow) ||
                       (valid_i && !vc_in_range);

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      error_q <= 1'b0;
    end else if (error_event) begin
      error_q <= 1'b1;
    end
  end

  // Report each protocol violation as it is observed.
  always @(posedge clk) begin
    if (!rst && error_event) begin
      $error("vc_credit_tx: protocol violation (ownership=%0b overflow=%b vc_id=%0d)",
             ownership_violation, credit_overflow, vc_id_i);
    end
  end

  assign error_o = error_q;
`else
  logic unused_overflow;
  assign unused_overflow = ^credit_overflow;
  assign error_o         = 1'b0;
`endif

endmodule

// File: tb/tb_vc_credit_tx.sv
// Self-checking bench for vc_credit_tx with VC_NUM=2, BUFFER_SIZE=4.
// A per-cycle model derived from the credit/ownership rules is compared
// against the DUT on every falling edge, plus hand-computed spot checks.
module tb_vc_credit_tx;
  import noc_params::*;

  localparam int VN = 2;
  localparam int BS = 4;
`ifdef CREDIT_CHECK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  flit_t         flit_i;
  logic          valid_i;
  logic [0:0]    vc_id_i;
  logic          ready_o;
  flit_t         flit_o;
  logic          valid_o;
  logic [0:0]    vc_id_o;
  logic [VN-1:0] credit_i;
  logic [VN-1:0] vc_free_o;
  logic          error_o;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  vc_credit_tx #(
    .VC_NUM     (VN),
    .BUFFER_SIZE(BS)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .flit_i   (flit_i),
    .valid_i  (valid_i),
    .vc_id_i  (vc_id_i),
    .ready_o  (ready_o),
    .flit_o   (flit_o),
    .valid_o  (valid_o),
    .vc_id_o  (vc_id_o),
    .credit_i (credit_i),
    .vc_free_o(vc_free_o),
    .error_o  (error_o)
  );

  // ---------------- behavioural model ----------------
  int    m_credit [VN];
  bit    m_active [VN];
  bit    m_valid;
  flit_t m_flit;
  bit    m_vc;
  bit    m_err;
  bit    m_xfer;

  function automatic int next_credit(input int c, input bit send, input bit ret);
    if (send && !ret) return c - 1;
    if (ret && !send && c < BS) return c + 1;
    return c;
  endfunction

  function automatic bit next_active(input bit a, input flit_label_t l);
    case (l)
      HEAD:    return 1'b1;
      BODY:    return a;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit violation(input bit a, input flit_label_t l);
    if (l == HEAD || l == HEADTAIL) return a;
    return !a;
  endfunction

  assign m_xfer = valid_i && (m_credit[vc_id_i] > 0);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int v = 0; v < VN; v++) begin
        m_credit[v] <= BS;
        m_active[v] <= 1'b0;
      end
      m_valid <= 1'b0;
      m_flit  <= '0;
      m_vc    <= 1'b0;
      m_err   <= 1'b0;
    end else begin
      for (int v = 0; v < VN; v++) begin
        m_credit[v] <= next_credit(m_credit[v], m_xfer && (vc_id_i == v), credit_i[v]);
        if (m_xfer && vc_id_i == v) m_active[v] <= next_active(m_active[v], flit_i.flit_label);
      end
      m_valid <= m_xfer;
      if (m_xfer) begin
        m_flit <= flit_i;
        m_vc   <= vc_id_i;
      end
      if (CHK_EN && ((credit_i[0] && m_credit[0] == BS) || (credit_i[1] && m_credit[1] == BS) ||
                     (m_xfer && violation(m_active[vc_id_i], flit_i.flit_label))))
        m_err <= 1'b1;
    end
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every DUT output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check_output("model_ready", 32'(ready_o), 32'(m_credit[vc_id_i] > 0));
      check_output("model_valid", 32'(valid_o), 32'(m_valid));
      check_output("model_flit", 32'(flit_o), 32'(m_flit));
      check_output("model_vc_id", 32'(vc_id_o), 32'(m_vc));
      check_output("model_vc_free", 32'(vc_free_o),
                   {30'd0, !m_active[1] && m_credit[1] == BS, !m_active[0] && m_credit[0] == BS});
      check_output("model_error", 32'(error_o), 32'(m_err));
    end
  end

  // ---------------- stimulus ----------------
  task automatic apply_stimulus(input bit v, input bit vc, input flit_label_t lab,
                                input logic [15:0] data, input logic [1:0] cr);
    @(posedge clk);
    #1;
    valid_i          = v;
    vc_id_i          = vc;
    flit_i.flit_label = lab;
    flit_i.data      = data;
    credit_i         = cr;
  endtask

  initial begin
    rst      = 1'b1;
    valid_i  = 1'b0;
    vc_id_i  = 1'b0;
    flit_i   = '0;
    credit_i = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk_en = 1'b1;

    // 1. reset state
    @(negedge clk);
    check_output("rst_vc_free", 32'(vc_free_o), 32'h3);
    check_output("rst_valid", 32'(valid_o), 32'h0);
    check_output("rst_ready", 32'(ready_o), 32'h1);
    check_output("rst_error", 32'(error_o), 32'h0);

    // 2. HEAD BODY BODY TAIL on VC0, no returns
    apply_stimulus(1, 0, HEAD, 16'hA0, 2'b00);
    apply_stimulus(1, 0, BODY, 16'hA1, 2'b00);
    @(negedge clk);
    check_output("t2_head_out", 32'(flit_o.data), 32'hA0);
    check_output("t2_free_after_head", 32'(vc_free_o), 32'h2);
    apply_stimulus(1, 0, BODY, 16'hA2, 2'b00);
    apply_stimulus(1, 0, TAIL, 16'hA3, 2'b00);
    apply_stimulus(0, 0, HEAD, 16'h00, 2'b00);
    @(negedge clk);
    check_output("t2_tail_out", 32'(flit_o.data), 32'hA3);
    check_output("t2_tail_valid", 32'(valid_o), 32'h1);
    check_output("t2_vc0_blocked", 32'(ready_o), 32'h0);
    check_output("t2_vc_free", 32'(vc_free_o), 32'h2);
    apply_stimulus(0, 1, HEAD, 16'h00, 2'b00);
    @(negedge clk);
    check_output("t2_vc1_ready", 32'(ready_o), 32'h1);

    // 3. single credit return on VC0
    apply_stimulus(0, 0, HEAD, 16'h00, 2'b01);
    @(negedge clk);
    check_output("t3_ready_same_cycle", 32'(ready_o), 32'h0);
    apply_stimulus(0, 0, HEAD, 16'h00, 2'b00);
    @(negedge clk);
    check_output("t3_ready_next_cycle", 32'(ready_o), 32'h1);
    apply_stimulus(1, 0, HEADTAIL, 16'hA4, 2'b00);
    apply_stimulus(0, 0, HEAD, 16'h00, 2'b00);
    @(negedge clk);
    check_output("t3_extra_flit", 32'(flit_o.data), 32'hA4);
    check_output("t3_blocked_again", 32'(ready_o), 32'h0);

    // 4. simultaneous transfer and return on VC1 at credit 2
    apply_stimulus(1, 1, HEAD, 16'hB0, 2'b00);
    apply_stimulus(1, 1, BODY, 16'hB1, 2'b00);
    apply_stimulus(1, 1, BODY, 16'hB2, 2'b10);
    apply_stimulus(1, 1, BODY, 16'hB3, 2'b00);
    apply_stimulus(1, 1, TAIL, 16'hB4, 2'b00);
    apply_stimulus(0, 1, HEAD, 16'h00, 2'b00);
    @(negedge clk);
    check_output("t4_tail_out", 32'(flit_o.data), 32'hB4);
    check_output("t4_vc_id_o", 32'(vc_id_o), 32'h1);
    check_output("t4_credit_exhausted", 32'(ready_o), 32'h0);

    // 5. refill VC0, then one surplus return
    repeat (4) apply_stimulus(0, 0, HEAD, 16'h00, 2'b01);
    apply_stimulus(0, 0, HEAD, 16'h00, 2'b00);
    @(negedge clk);
    check_output("t5_vc0_free", 32'(vc_free_o), 32'h1);
    check_output("t5_no_error_yet", 32'(error_o), 32'h0);
    apply_stimulus(0, 0, HEAD, 16'h00, 2'b01);
    apply_stimulus(0, 0, HEAD, 16'h00, 2'b00);
    @(negedge clk);
    check_output("t5_saturated_free", 32'(vc_free_o), 32'h1);
    check_output("t5_overflow_error", 32'(error_o), 32'(CHK_EN));

    // 6. BODY to idle VC1, then reset mid-packet
    repeat (2) apply_stimulus(0, 1, HEAD, 16'h00, 2'b10);
    apply_stimulus(1, 1, BODY, 16'hC5, 2'b00);
    apply_stimulus(0, 1, HEAD, 16'h00, 2'b00);
    @(negedge clk);
    check_output("t6_body_fwd", 32'(flit_o.data), 32'hC5);
    check_output("t6_body_valid", 32'(valid_o), 32'h1);
    check_output("t6_vc_free", 32'(vc_free_o), 32'h1);
    check_output("t6_error", 32'(error_o), 32'(CHK_EN));
    apply_stimulus(1, 0, HEAD, 16'hD0, 2'b00);
    apply_stimulus(1, 0, BODY, 16'hD1, 2'b00);
    @(posedge clk);
    #1;
    flit_i.data = 16'hD2;
    rst         = 1'b1;
    @(negedge clk);
    check_output("t6_rst_valid", 32'(valid_o), 32'h0);
    check_output("t6_rst_flit", 32'(flit_o), 32'h0);
    check_output("t6_rst_vc_free", 32'(vc_free_o), 32'h3);
    check_output("t6_rst_error", 32'(error_o), 32'h0);
    @(posedge clk);
    #1;
    rst     = 1'b0;
    valid_i = 1'b0;
    @(negedge clk);
    check_output("t6_post_rst_valid", 32'(valid_o), 32'h0);
    check_output("t6_post_rst_ready", 32'(ready_o), 32'h1);
    apply_stimulus(1, 0, HEADTAIL, 16'hE7, 2'b00);
    apply_stimulus(0, 0, HEAD, 16'h00, 2'b00);
    @(negedge clk);
    check_output("t6_resume_flit", 32'(flit_o.data), 32'hE7);
    check_output("t6_resume_free", 32'(vc_free_o), 32'h2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
